slicel_cfg_loader: RTL and testbench

Configuration sequencer for one `slicel`. It accepts the slice's 143-bit configuration frame as a stream of narrow words over a valid/ready handshake and shifts the frame serially into the slice's config chain. It commits the frame to the slice's parallel config ports, then drives `cen`/`reg_ce` to switch the slice from config mode to run mode. It sits between the fabric's bitstream distributor and each `slicel` instance.

---
 rtl/fabric_cfg_pkg.sv | 25 ++
 rtl/cfg_serializer.sv | 83 ++++++++
 rtl/slicel_cfg_loader.sv | 140 ++++++++++++++
 tb/tb_slicel_cfg_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for fabric configuration loaders: frame geometry,
// field offsets within the slicel frame and the loader FSM states.
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SHIFT,
        ST_COMMIT,
        ST_RUN
    } cfg_state_e;

    localparam int SLICEL_CFG_BITS = 143;
    localparam int CFG_WORD_W      = 8;

    localparam int LUT_CFG_LSB = 0;
    localparam int MUX_CFG_LSB = 132;
    localparam int CC_CFG_LSB  = 134;
    localparam int REG_CFG_LSB = 135;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Staging register for one config frame plus the serial shifter that feeds
// the slice chain MSB first.
module cfg_serializer
    import fabric_cfg_pkg::*;
#(
    parameter int  CFG_BITS  = SLICEL_CFG_BITS,
    parameter int  WORD_W    = CFG_WORD_W,
    localparam int NUM_WORDS = ceil_div(CFG_BITS, WORD_W),
    localparam int WIDX_W    = $clog2(NUM_WORDS),
    localparam int BIDX_W    = $clog2(CFG_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                word_we,
    input  logic [WIDX_W-1:0]   word_idx,
    input  logic [WORD_W-1:0]   word_data,
    input  logic                shift_start,
    input  logic                shift_active,
    output logic [CFG_BITS-1:0] staging,
    output logic                shift_last,
    output logic                cfg_bit,
    output logic                cfg_shift
);

    // Position of frame bit CFG_BITS-1 inside the final (padded) word.
    localparam int LAST_WORD_TOP = (CFG_BITS - 1) - (NUM_WORDS - 1) * WORD_W;

    logic [CFG_BITS-1:0] staging_q, staging_d;
    logic [BIDX_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BIDX_W-1:0]   next_idx;
    logic                cfg_bit_q, cfg_bit_d;
    logic                cfg_shift_q, cfg_shift_d;

    always_comb begin
        staging_d = staging_q;
        if (word_we) begin
            for (int i = 0; i < CFG_BITS; i++) begin
                if (i / WORD_W == int'(word_idx)) begin
                    staging_d[i] = word_data[i % WORD_W];
                end
            end
        end
    end

    assign shift_last = shift_active && (bit_cnt_q == BIDX_W'(CFG_BITS - 1));
    assign next_idx   = BIDX_W'(CFG_BITS - 2) - bit_cnt_q;

    // The top bit is taken straight from the incoming last word so the
    // first serial bit appears on the same edge the FSM enters SHIFT.
    always_comb begin
        bit_cnt_d   = '0;
        cfg_bit_d   = 1'b0;
        cfg_shift_d = 1'b0;
        if (shift_start) begin
            cfg_shift_d = 1'b1;
            cfg_bit_d   = word_data[LAST_WORD_TOP];
        end else if (shift_active && !clear && !shift_last) begin
            bit_cnt_d   = bit_cnt_q + BIDX_W'(1);
            cfg_shift_d = 1'b1;
            cfg_bit_d   = staging_q[next_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_q   <= '0;
            bit_cnt_q   <= '0;
            cfg_bit_q   <= 1'b0;
            cfg_shift_q <= 1'b0;
        end else begin
            staging_q   <= staging_d;
            bit_cnt_q   <= bit_cnt_d;
            cfg_bit_q   <= cfg_bit_d;
            cfg_shift_q <= cfg_shift_d;
        end
    end

    assign staging   = staging_q;
    assign cfg_bit   = cfg_bit_q;
    assign cfg_shift = cfg_shift_q;

endmodule

// File: rtl/slicel_cfg_loader.sv
// Loads one slicel configuration frame from a word stream, shifts it into the
// slice chain, commits it to the parallel ports and switches the slice to run.
module slicel_cfg_loader
    import fabric_cfg_pkg::*;
#(
    parameter int  CFG_BITS  = SLICEL_CFG_BITS,
    parameter int  WORD_W    = CFG_WORD_W,
    localparam int NUM_WORDS = ceil_div(CFG_BITS, WORD_W),
    localparam int WIDX_W    = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_bit,
    output logic              cfg_shift,
    output logic [131:0]      luts_config_out,
    output logic [1:0]        inter_lut_mux_config,
    output logic              config_use_cc,
    output logic [7:0]        regs_config_out,
    output logic              cen,
    output logic              reg_ce,
    output logic              busy,
    output logic              done
);

    cfg_state_e          state_q, state_d;
    logic [WIDX_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CFG_BITS-1:0] frame_q, frame_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cen_q, cen_d;
    logic                reg_ce_q, reg_ce_d;

    logic                loading;
    logic                abort_load;
    logic                accept;
    logic                last_word;
    logic                shift_last;
    logic [CFG_BITS-1:0] staging;

    assign loading    = (state_q == ST_FILL) || (state_q == ST_SHIFT);
    assign abort_load = abort && loading;
    assign accept     = (state_q == ST_FILL) && cfg_valid && cfg_ready_q && !abort;
    assign last_word  = accept && (word_cnt_q == WIDX_W'(NUM_WORDS - 1));

    cfg_serializer #(
        .CFG_BITS (CFG_BITS),
        .WORD_W   (WORD_W)
    ) u_serializer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (abort_load),
        .word_we      (accept),
        .word_idx     (word_cnt_q),
        .word_data    (cfg_data),
        .shift_start  (last_word),
        .shift_active (state_q == ST_SHIFT),
        .staging      (staging),
        .shift_last   (shift_last),
        .cfg_bit      (cfg_bit),
        .cfg_shift    (cfg_shift)
    );

    // Handshake and busy follow the upcoming state; the slice enables follow
    // the current one, so run mode starts the cycle after the done pulse.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        frame_d    = frame_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start && !abort) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    word_cnt_d = '0;
                end else if (last_word) begin
                    state_d    = ST_SHIFT;
                    word_cnt_d = '0;
                end else if (accept) begin
                    word_cnt_d = word_cnt_q + WIDX_W'(1);
                end
            end
            ST_SHIFT: begin
                if (abort)           state_d = ST_IDLE;
                else if (shift_last) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                frame_d = staging;
                state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        cfg_ready_d = (state_d == ST_FILL);
        busy_d      = (state_d == ST_FILL) || (state_d == ST_SHIFT);
        done_d      = (state_q == ST_COMMIT);
        cen_d       = (state_q != ST_RUN);
        reg_ce_d    = (state_q == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            frame_q     <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cen_q       <= 1'b1;
            reg_ce_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            frame_q     <= frame_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cen_q       <= cen_d;
            reg_ce_q    <= reg_ce_d;
        end
    end

    assign cfg_ready            = cfg_ready_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign cen                  = cen_q;
    assign reg_ce               = reg_ce_q;
    assign luts_config_out      = frame_q[MUX_CFG_LSB-1:LUT_CFG_LSB];
    assign inter_lut_mux_config = frame_q[CC_CFG_LSB-1:MUX_CFG_LSB];
    assign config_use_cc        = frame_q[CC_CFG_LSB];
    assign regs_config_out      = frame_q[CFG_BITS-1:REG_CFG_LSB];

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Bench for slicel_cfg_loader: random frames and stalls against a cycle-window
// model of the load protocol, plus literal checks on a known frame.
module tb_slicel_cfg_loader;

    localparam logic [131:0] LUT_A   = 132'h0_1234_5678_9ABC_DEF0_0FED_CBA9_8765_43A5;
    localparam logic [142:0] FRAME_A = {8'b10110010, 1'b1, 2'b10, LUT_A};
    localparam int           BIG     = 1 << 30;

    logic         clk, rst_n, start, abort, cfg_valid;
    logic [7:0]   cfg_data;
    logic         cfg_ready, cfg_bit, cfg_shift;
    logic [131:0] luts_config_out;
    logic [1:0]   inter_lut_mux_config;
    logic         config_use_cc;
    logic [7:0]   regs_config_out;
    logic         cen, reg_ce, busy, done;
    logic [142:0] dut_frame;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Model state: frames and the cycle windows in which outputs must be active.
    logic [142:0] prev_frame, pending_frame;
    int commit_cyc, s_cyc;
    int ready_from, ready_to, busy_from, busy_to, shift_from, shift_to;
    int run_from, run_to, old_run_from, old_run_to;
    bit pin_a;
    int pin_abort_cyc;

    logic [142:0] cap;
    int           cap_cnt;
    logic         first_bit;

    slicel_cfg_loader dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .cfg_data             (cfg_data),
        .cfg_valid            (cfg_valid),
        .cfg_ready            (cfg_ready),
        .cfg_bit              (cfg_bit),
        .cfg_shift            (cfg_shift),
        .luts_config_out      (luts_config_out),
        .inter_lut_mux_config (inter_lut_mux_config),
        .config_use_cc        (config_use_cc),
        .regs_config_out      (regs_config_out),
        .cen                  (cen),
        .reg_ce               (reg_ce),
        .busy                 (busy),
        .done                 (done)
    );

    assign dut_frame = {regs_config_out, config_use_cc, inter_lut_mux_config, luts_config_out};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    function automatic bit in_range(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic logic [7:0] word_of(input logic [142:0] f, input int k);
        logic [143:0] w;
        w = {1'b1, f};
        return w[k*8 +: 8];
    endfunction

    function automatic logic [142:0] rand_frame();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[142:0];
    endfunction

    function automatic logic [142:0] shown_frame(input int c);
        return (commit_cyc >= 0 && c >= commit_cyc) ? pending_frame : prev_frame;
    endfunction

    task automatic check_output(input string name, input logic [142:0] actual,
                                input logic [142:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycle, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int c);
        while (cycle < c) tick();
    endtask

    task automatic model_reset();
        prev_frame    = '0;
        pending_frame = '0;
        commit_cyc    = -1;
        s_cyc         = 0;
        ready_from = 1; ready_to = 0;
        busy_from  = 1; busy_to  = 0;
        shift_from = 1; shift_to = 0;
        run_from   = 1; run_to   = 0;
        old_run_from = 1; old_run_to = 0;
    endtask

    // Start edge s: a run in progress ends there, cen rises one edge later.
    task automatic model_begin(input logic [142:0] f, input int s);
        prev_frame    = shown_frame(cycle);
        pending_frame = f;
        s_cyc         = s;
        if (in_range(s, run_from, run_to)) begin
            old_run_from = run_from;
            old_run_to   = s;
        end else begin
            old_run_from = 1;
            old_run_to   = 0;
        end
        run_from = 1; run_to = 0;
    endtask

    // Full load with random idle cycles on cfg_valid (idle_pct percent).
    task automatic apply_stimulus(input logic [142:0] f, input int idle_pct);
        int stalls[18];
        int total;
        int s, l;
        total = 0;
        for (int k = 0; k < 18; k++) begin
            stalls[k] = 0;
            while (int'($urandom_range(0, 99)) < idle_pct && stalls[k] < 5) stalls[k]++;
            total += stalls[k];
        end
        s = cycle + 1;
        l = s + 18 + total;
        model_begin(f, s);
        ready_from = s;     ready_to = l - 1;
        busy_from  = s;     busy_to  = l + 142;
        shift_from = l;     shift_to = l + 142;
        commit_cyc = l + 144;
        run_from   = commit_cyc + 1;
        run_to     = BIG;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            repeat (stalls[k]) begin
                cfg_valid = 1'b0;
                cfg_data  = 8'($urandom);
                tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = word_of(f, k);
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic abort_after(input logic [142:0] f, input int n);
        int s, a;
        s = cycle + 1;
        a = s + n + 1;
        model_begin(f, s);
        commit_cyc    = -1;
        ready_from    = s; ready_to = a - 1;
        busy_from     = s; busy_to  = a - 1;
        pin_abort_cyc = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = word_of(f, k);
            tick();
        end
        abort     = 1'b1;
        cfg_data  = word_of(f, n);
        tick();
        abort     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check_output("rst_cen", 143'(cen), 143'(1'b1));
            check_output("rst_reg_ce", 143'(reg_ce), '0);
            check_output("rst_cfg_ready", 143'(cfg_ready), '0);
            check_output("rst_cfg_shift", 143'(cfg_shift), '0);
            check_output("rst_cfg_bit", 143'(cfg_bit), '0);
            check_output("rst_busy", 143'(busy), '0);
            check_output("rst_done", 143'(done), '0);
            check_output("rst_fields", dut_frame, '0);
        end else begin
            check_output("done", 143'(done), 143'(cycle == commit_cyc));
            check_output("cfg_ready", 143'(cfg_ready), 143'(in_range(cycle, ready_from, ready_to)));
            check_output("busy", 143'(busy), 143'(in_range(cycle, busy_from, busy_to)));
            check_output("cfg_shift", 143'(cfg_shift), 143'(in_range(cycle, shift_from, shift_to)));
            check_output("cen", 143'(cen), 143'(!(in_range(cycle, run_from, run_to) ||
                                                  in_range(cycle, old_run_from, old_run_to))));
            check_output("reg_ce", 143'(reg_ce), 143'(in_range(cycle, run_from, run_to) ||
                                                      in_range(cycle, old_run_from, old_run_to)));
            check_output("fields", dut_frame, shown_frame(cycle));
            if (in_range(cycle, shift_from, shift_to))
                check_output("cfg_bit", 143'(cfg_bit), 143'(pending_frame[142 - (cycle - shift_from)]));

            if (cycle == busy_from) begin
                cap     = '0;
                cap_cnt = 0;
            end
            if (cfg_shift) begin
                if (cap_cnt == 0) first_bit = cfg_bit;
                cap = {cap[141:0], cfg_bit};
                cap_cnt++;
            end

            if (done && pin_a) begin
                check_output("pin_latency", 143'(cycle - s_cyc + 1), 143'(163));
                check_output("pin_regs", 143'(regs_config_out), 143'(8'b10110010));
                check_output("pin_use_cc", 143'(config_use_cc), 143'(1'b1));
                check_output("pin_mux", 143'(inter_lut_mux_config), 143'(2'b10));
                check_output("pin_first_bit", 143'(first_bit), 143'(1'b1));
                check_output("pin_last_bit", 143'(cap[0]), 143'(1'b1));
                check_output("pin_shift_count", 143'(cap_cnt), 143'(143));
                check_output("pin_serial_frame", cap, FRAME_A);
            end
            if (cycle == pin_abort_cyc) begin
                check_output("pin_abort_regs", 143'(regs_config_out), 143'(8'b10110010));
                check_output("pin_abort_luts", 143'(luts_config_out), 143'(LUT_A));
            end
        end
    end

    initial begin
        logic [142:0] f;
        int old_commit;
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        pin_a = 1'b0; pin_abort_cyc = -1;
        cap = '0; cap_cnt = 0; first_bit = 1'b0;
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();

        pin_a = 1'b1;
        apply_stimulus(FRAME_A, 0);
        run_until(commit_cyc + 3);
        pin_a = 1'b0;

        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();

        abort_after(rand_frame(), 9);
        repeat (3) tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();

        apply_stimulus(rand_frame(), 30);
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(commit_cyc + 3);

        for (int n = 0; n < 4; n++) begin
            f = rand_frame();
            apply_stimulus(f, 30);
            run_until(commit_cyc + 2);
        end

        apply_stimulus(rand_frame(), 30);
        repeat (72) tick();
        old_commit = commit_cyc;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        run_until(old_commit + 10);

        apply_stimulus(rand_frame(), 30);
        run_until(commit_cyc + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
